led_pattern_gen: RTL and testbench

Parametrised LED sequencer for the iCE40 board: N one-hot/binary LED outputs advanced on a programmable prescaled tick, with run-time mode select.
- Modes: configurable forward/back "walk", plain ping-pong scan, free-running binary count, and hold.
- Sits directly between the board clock and the LED pins; `tick` is exported for neighbouring status logic.

---
 rtl/led_pkg.sv | 22 ++
 rtl/led_prescaler.sv | 27 ++
 rtl/led_pattern_gen.sv | 164 ++++++++++++++++
 tb/tb_led_pattern_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared encodings for the LED sequencer: mode, walk phase, travel direction and
// the trail duty threshold used when LED_FADE_EN is defined.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_WALK  = 2'd0,
    MODE_SCAN  = 2'd1,
    MODE_COUNT = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_e;

  typedef enum logic {
    PHASE_A = 1'b0,
    PHASE_B = 1'b1
  } phase_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam logic [7:0] PWM_TRAIL = 8'd64;

endpackage

// File: rtl/led_prescaler.sv
// Tick prescaler: counts 0..DIV-1 while en is high and flags the last count.
// Holding en low freezes the count so the period resumes where it stopped.
module led_prescaler #(
  parameter int DIV = 1000002
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED sequencer top: mode FSM, walk/scan/count stepping and the registered LED drive.
// Define LED_FADE_EN to add a 25% duty trail on the previously lit LED in WALK/SCAN.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int N    = 8,
  parameter int DIV  = 1000002,
  parameter int FWD  = 2,
  parameter int BACK = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [1:0]   mode,
  output logic [N-1:0] led,
  output logic         tick,
  output logic         dir
);

  localparam int PW = $clog2(N);

  // Whole sequencer state in one struct so it can be probed as a unit.
  typedef struct packed {
    mode_e         cur_mode;
    phase_e        phase;
    logic          dir;
    logic [PW-1:0] pos;
    logic [N-1:0]  cnt;
  } state_t;

  state_t       st;
  state_t       st_n;
  logic [N-1:0] trail_mask;

  function automatic state_t init_state(mode_e m);
    state_t s;
    s.cur_mode = m;
    s.phase    = PHASE_A;
    s.dir      = DIR_UP;
    s.pos      = '0;
    s.cnt      = '0;
    return s;
  endfunction

  function automatic state_t step(state_t s);
    state_t r  = s;
    int     p  = int'(s.pos);
    int     np = p;
    case (s.cur_mode)
      MODE_WALK: begin
        if (s.phase == PHASE_A) begin
          if (s.dir == DIR_UP) begin
            if (p + FWD >= N - 1) begin
              np    = N - 1;
              r.dir = DIR_DOWN;
            end else begin
              np      = p + FWD;
              r.phase = PHASE_B;
            end
          end else begin
            if (p <= FWD) begin
              np    = 0;
              r.dir = DIR_UP;
            end else begin
              np      = p - FWD;
              r.phase = PHASE_B;
            end
          end
        end else begin
          np      = (s.dir == DIR_UP) ? p - BACK : p + BACK;
          r.phase = PHASE_A;
        end
      end
      MODE_SCAN: begin
        if (s.dir == DIR_UP) np = (p == N - 1) ? p - 1 : p + 1;
        else                 np = (p == 0) ? p + 1 : p - 1;
        // Direction flips on the tick that lands on an end LED.
        if (np == N - 1)     r.dir = DIR_DOWN;
        else if (np == 0)    r.dir = DIR_UP;
        else if (p == N - 1) r.dir = DIR_DOWN;
        else if (p == 0)     r.dir = DIR_UP;
      end
      MODE_COUNT: r.cnt = s.cnt + N'(1);
      default: ;
    endcase
    r.pos = PW'(np);
    return r;
  endfunction

  function automatic logic [N-1:0] pattern(state_t s);
    if (s.cur_mode == MODE_COUNT) return s.cnt;
    return N'(1) << s.pos;
  endfunction

  led_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick)
  );

  always_comb begin
    st_n = st;
    if (tick) begin
      if (mode_e'(mode) != st.cur_mode) st_n = init_state(mode_e'(mode));
      else                              st_n = step(st);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= init_state(MODE_WALK);
      led <= N'(1);
    end else begin
      st  <= st_n;
      led <= pattern(st_n) | trail_mask;
    end
  end

  assign dir = st.dir;

`ifdef LED_FADE_EN
  logic [7:0]    pwm;
  logic [7:0]    pwm_n;
  logic [PW-1:0] prev_pos;
  logic [PW-1:0] prev_n;
  logic          trail;
  logic          trail_n;

  always_comb begin
    pwm_n   = pwm + 8'd1;
    prev_n  = prev_pos;
    trail_n = trail;
    if (tick) begin
      if (st_n.cur_mode != st.cur_mode) begin
        trail_n = 1'b0;
      end else if ((st.cur_mode == MODE_WALK || st.cur_mode == MODE_SCAN) &&
                   st_n.pos != st.pos) begin
        prev_n  = st.pos;
        trail_n = 1'b1;
      end
    end
    trail_mask = '0;
    if (trail_n && pwm_n < PWM_TRAIL &&
        (st_n.cur_mode == MODE_WALK || st_n.cur_mode == MODE_SCAN))
      trail_mask = N'(1) << prev_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm      <= '0;
      prev_pos <= '0;
      trail    <= 1'b0;
    end else begin
      pwm      <= pwm_n;
      prev_pos <= prev_n;
      trail    <= trail_n;
    end
  end
`else
  assign trail_mask = '0;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: an 8-LED and a 4-LED instance share stimulus and are
// compared every cycle against a step-count based model, plus directed literal checks.
module tb_led_pattern_gen;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic [1:0] mode  = 2'd0;

  logic [7:0] led_a;
  logic       tick_a;
  logic       dir_a;
  logic [3:0] led_b;
  logic       tick_b;
  logic       dir_b;

  always #5 clk = ~clk;

  led_pattern_gen #(.N(8), .DIV(4), .FWD(2), .BACK(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .led(led_a), .tick(tick_a), .dir(dir_a)
  );

  led_pattern_gen #(.N(4), .DIV(4), .FWD(2), .BACK(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
    .led(led_b), .tick(tick_b), .dir(dir_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Model: ticks come every 4 enabled cycles; outputs are a pure function of
  // (current mode, steps taken since entering it).
  int wpos[2][64];
  int wdir[2][64];
  int wlen[2];
  int m_pre  = 0;
  int m_mode = 0;
  int m_k    = 0;
  logic m_t;

  task automatic build_walk(input int idx, input int n);
    int p   = 0;
    int len = 0;
    while (1) begin
      if (p + 2 >= n - 1) begin
        wpos[idx][len] = n - 1; wdir[idx][len] = 1; len++; p = n - 1;
        break;
      end
      p += 2; wpos[idx][len] = p; wdir[idx][len] = 0; len++;
      p -= 1; wpos[idx][len] = p; wdir[idx][len] = 0; len++;
    end
    while (1) begin
      if (p <= 2) begin
        wpos[idx][len] = 0; wdir[idx][len] = 0; len++;
        break;
      end
      p -= 2; wpos[idx][len] = p; wdir[idx][len] = 1; len++;
      p += 1; wpos[idx][len] = p; wdir[idx][len] = 1; len++;
    end
    wlen[idx] = len;
  endtask

  function automatic logic [31:0] exp_led(int idx, int n, int md, int k);
    int per;
    int m;
    case (md)
      0: return 32'(1) << ((k == 0) ? 0 : wpos[idx][(k - 1) % wlen[idx]]);
      1: begin
        per = 2 * (n - 1);
        m   = k % per;
        return 32'(1) << ((m <= n - 1) ? m : per - m);
      end
      2: return 32'(k % (1 << n));
      default: return 32'd1;
    endcase
  endfunction

  function automatic logic exp_dir(int idx, int n, int md, int k);
    case (md)
      0: return (k == 0) ? 1'b0 : (wdir[idx][(k - 1) % wlen[idx]] != 0);
      1: return (k % (2 * (n - 1))) >= n - 1;
      default: return 1'b0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pre  = 0;
      m_mode = 0;
      m_k    = 0;
    end else begin
      m_t = en && (m_pre == 3);
      if (en) m_pre = (m_pre + 1) % 4;
      if (m_t) begin
        if (int'(mode) != m_mode) begin
          m_mode = int'(mode);
          m_k    = 0;
        end else if (m_mode != 3) begin
          m_k++;
        end
      end
    end
  end

  bit chk_on = 1'b0;

  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      check("tick8", 32'(tick_a), 32'(en && m_pre == 3));
      check("led8",  32'(led_a),  exp_led(0, 8, m_mode, m_k));
      check("dir8",  32'(dir_a),  32'(exp_dir(0, 8, m_mode, m_k)));
      check("tick4", 32'(tick_b), 32'(en && m_pre == 3));
      check("led4",  32'(led_b),  exp_led(1, 4, m_mode, m_k));
      check("dir4",  32'(dir_b),  32'(exp_dir(1, 4, m_mode, m_k)));
    end
  end

  task automatic wait_tick();
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (tick_a) seen = 1'b1;
    end
    check("tick_seen", 32'(seen), 32'd1);
    @(posedge clk);
    #1;
  endtask

  int walk_exp[22] = '{2, 1, 3, 2, 4, 3, 5, 4, 6, 5, 7, 5, 6, 4, 5, 3, 4, 2, 3, 1, 2, 0};
  int scan_exp[15] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
  int scan_dir[15] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};

  initial begin
    bit found;
    build_walk(0, 8);
    build_walk(1, 4);

    check("pin_walk_len",  32'(wlen[0]), 32'd22);
    check("pin_walk_k11",  exp_led(0, 8, 0, 11), 32'h80);
    check("pin_walk_dir",  32'(exp_dir(0, 8, 0, 11)), 32'd1);
    check("pin_scan_k21",  exp_led(0, 8, 1, 21), 32'h80);
    check("pin_scan_dir8", 32'(exp_dir(0, 8, 1, 8)), 32'd1);
    check("pin_count4",    exp_led(1, 4, 2, 17), 32'd1);

    #12;
    check("rst_led8", 32'(led_a),  32'h01);
    check("rst_tick", 32'(tick_a), 32'd0);
    check("rst_dir",  32'(dir_a),  32'd0);
    check("rst_led4", 32'(led_b),  32'h1);

    @(posedge clk); #1;
    rst_n = 1'b1; en = 1'b1; mode = 2'd0; chk_on = 1'b1;

    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("first_tick", 32'(tick_a), 32'(c == 4));
    end
    @(posedge clk); #1;

    foreach (walk_exp[i]) exp_q.push_back(32'(1) << walk_exp[i]);
    for (int i = 0; i < 22; i++) begin
      if (i > 0) wait_tick();
      check("walk_led", 32'(led_a), exp_q.pop_front());
      check("walk_dir", 32'(dir_a), 32'(i >= 10 && i < 21));
    end

    mode = 2'd1;
    wait_tick();
    check("scan_entry_led", 32'(led_a), 32'h01);
    for (int i = 0; i < 15; i++) begin
      wait_tick();
      check("scan_led", 32'(led_a), 32'(1) << scan_exp[i]);
      check("scan_dir", 32'(dir_a), 32'(scan_dir[i]));
    end

    mode = 2'd2;
    wait_tick();
    check("count_entry_led4", 32'(led_b), 32'd0);
    check("count_entry_led8", 32'(led_a), 32'd0);
    for (int i = 0; i < 16; i++) begin
      wait_tick();
      check("count_led4", 32'(led_b), 32'((i + 1) % 16));
      check("count_led8", 32'(led_a), 32'(i + 1));
    end
    mode = 2'd1;
    wait_tick();
    check("count_to_scan_led4", 32'(led_b), 32'b0001);
    check("count_to_scan_led8", 32'(led_a), 32'h01);

    @(posedge clk); #1;
    @(posedge clk); #1;
    en = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("freeze_tick", 32'(tick_a), 32'd0);
      check("freeze_led",  32'(led_a),  32'h01);
      @(posedge clk); #1;
    end
    en = 1'b1;
    @(negedge clk);
    check("resume_tick_1st", 32'(tick_a), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("resume_tick_2nd", 32'(tick_a), 32'd1);
    @(posedge clk); #1;

    for (int c = 0; c < 2500; c++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end

    en = 1'b1;
    mode = 2'd0;
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      @(negedge clk);
      if (m_mode == 0 && led_a == 8'h20) found = 1'b1;
    end
    check("walk_pos5_seen", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_led8", 32'(led_a),  32'h01);
    check("async_rst_dir",  32'(dir_a),  32'd0);
    check("async_rst_tick", 32'(tick_a), 32'd0);
    check("async_rst_led4", 32'(led_b),  32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
